// File: rtl/test_status_reporter.sv
// End-of-test reporter: mailbox store or stall watchdog -> test_done/done_ack.
// Optional stall watchdog: define TEST_STATUS_STALL_TIMEOUT_EN to compile it in.
package memory_pkg;
    localparam int MEM_ADDR_WIDTH = 16;
endpackage

module test_status_reporter #(
    parameter int                ADDR_W      = memory_pkg::MEM_ADDR_WIDTH,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h7FFC,
    parameter int                STALL_LIMIT = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dmem_wr_en,
    input  logic [ADDR_W-1:0] dmem_wr_addr,
    input  logic [DATA_W-1:0] dmem_wr_data,
    input  logic              retire_valid,
    input  logic              done_ack,
    output logic              test_done,
    output logic              test_pass,
    output logic [DATA_W-1:0] test_code,
    output logic              timeout,
    output logic [31:0]       retire_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_done;
    logic              r_pass;
    logic              w_pass_nxt;
    logic [DATA_W-1:0] r_code;
    logic [DATA_W-1:0] w_code_nxt;
    logic [31:0]       r_count;
    logic [31:0]       w_count_nxt;
    logic              w_hit;
    logic              w_stall;

    assign w_hit = dmem_wr_en && (dmem_wr_addr == TOHOST_ADDR);

`ifdef TEST_STATUS_STALL_TIMEOUT_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [SW-1:0] r_stall;
    logic [SW-1:0] w_stall_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;

    // This cycle is the STALL_LIMIT-th consecutive one without a retire.
    assign w_stall = !retire_valid && (r_stall == SW'(STALL_LIMIT - 1));
    assign timeout = r_timeout;
`else
    assign w_stall = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_hit || w_stall) w_state_nxt = S_DONE;
            S_DONE:  if (done_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pass_nxt  = r_pass;
        w_code_nxt  = r_code;
        w_count_nxt = r_count;
`ifdef TEST_STATUS_STALL_TIMEOUT_EN
        w_stall_nxt   = r_stall;
        w_timeout_nxt = r_timeout;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pass_nxt  = 1'b0;
                    w_code_nxt  = '0;
                    w_count_nxt = '0;
`ifdef TEST_STATUS_STALL_TIMEOUT_EN
                    w_stall_nxt   = '0;
                    w_timeout_nxt = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (retire_valid && (r_count != 32'hFFFF_FFFF))
                    w_count_nxt = r_count + 32'd1;
`ifdef TEST_STATUS_STALL_TIMEOUT_EN
                w_stall_nxt = retire_valid ? '0 : r_stall + SW'(1);
`endif
                // Mailbox has priority over a coincident stall.
                if (w_hit) begin
                    w_code_nxt = dmem_wr_data;
                    w_pass_nxt = (dmem_wr_data == DATA_W'(1));
                end else if (w_stall) begin
                    w_code_nxt = '0;
                    w_pass_nxt = 1'b0;
`ifdef TEST_STATUS_STALL_TIMEOUT_EN
                    w_timeout_nxt = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_code  <= '0;
            r_count <= '0;
`ifdef TEST_STATUS_STALL_TIMEOUT_EN
            r_stall   <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_done  <= (w_state_nxt == S_DONE);
            r_pass  <= w_pass_nxt;
            r_code  <= w_code_nxt;
            r_count <= w_count_nxt;
`ifdef TEST_STATUS_STALL_TIMEOUT_EN
            r_stall   <= w_stall_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign test_done    = r_done;
    assign test_pass    = r_pass;
    assign test_code    = r_code;
    assign retire_count = r_count;

endmodule
